// File: rtl/tlb_entry_pkg.sv
// tlb_entry_pkg: shared flag layout and entry record for the TLB entry cache.
package tlb_entry_pkg;
  localparam int NUM_FLAGS = 12;
  localparam int PPN_W = 20;
  localparam int FLAG_U = 11;
  localparam int FLAG_AE = 10;
  localparam int FLAG_SW = 9;
  localparam int FLAG_SX = 8;
  localparam int FLAG_SR = 7;
  localparam int FLAG_PW = 6;
  localparam int FLAG_PX = 5;
  localparam int FLAG_PR = 4;
  localparam int FLAG_PAL = 3;
  localparam int FLAG_PAA = 2;
  localparam int FLAG_EFF = 1;
  localparam int FLAG_C = 0;
  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic [NUM_FLAGS-1:0] flags;
  } tlb_entry_t;
endpackage

// File: rtl/tlb_entry_cache_if.sv
// tlb_entry_cache_if: lookup, refill and sfence bundle; perf counters exist only with TLB_ENTRY_CACHE_PERF_EN.
interface tlb_entry_cache_if #(parameter int VPN_BITS = 27, parameter int PPN_BITS = 20);
  import tlb_entry_pkg::*;
  logic req_valid;
  logic [VPN_BITS-1:0] req_vpn;
  logic resp_valid;
  logic resp_hit;
  logic [PPN_BITS-1:0] resp_ppn;
  logic [NUM_FLAGS-1:0] resp_flags;
  logic refill_valid;
  logic refill_ready;
  logic [VPN_BITS-1:0] refill_vpn;
  logic [PPN_BITS-1:0] refill_ppn;
  logic [NUM_FLAGS-1:0] refill_flags;
  logic sfence_valid;
  logic sfence_rs1;
  logic [VPN_BITS-1:0] sfence_vpn;
`ifdef TLB_ENTRY_CACHE_PERF_EN
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;
`endif
  modport master (
    output req_valid, req_vpn, refill_valid, refill_vpn, refill_ppn, refill_flags,
           sfence_valid, sfence_rs1, sfence_vpn,
    input resp_valid, resp_hit, resp_ppn, resp_flags, refill_ready
`ifdef TLB_ENTRY_CACHE_PERF_EN
    , input perf_hits, perf_misses
`endif
  );
  modport slave (
    input req_valid, req_vpn, refill_valid, refill_vpn, refill_ppn, refill_flags,
          sfence_valid, sfence_rs1, sfence_vpn,
    output resp_valid, resp_hit, resp_ppn, resp_flags, refill_ready
`ifdef TLB_ENTRY_CACHE_PERF_EN
    , output perf_hits, perf_misses
`endif
  );
endinterface

// File: rtl/tlb_entry_victim_sel.sv
// tlb_entry_victim_sel: picks the refill slot (matching entry, else lowest invalid, else round-robin pointer).
module tlb_entry_victim_sel #(
  parameter int ENTRIES = 8,
  localparam int PW = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid,
  input  logic [ENTRIES-1:0] hit,
  input  logic [PW-1:0]      ptr,
  output logic [ENTRIES-1:0] sel,
  output logic               adv
);
  always_comb begin
    adv = !(|hit) && (&valid);
    sel = (|hit) ? hit : !(&valid) ? (~valid & (valid + ENTRIES'(1))) : (ENTRIES'(1) << ptr);
  end
endmodule

// File: rtl/tlb_entry_cache.sv
// tlb_entry_cache: fully-associative ppn/flag cache with PTW refill and sfence; TLB_ENTRY_CACHE_PERF_EN adds hit/miss counters.
module tlb_entry_cache
  import tlb_entry_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int VPN_BITS = 27,
  parameter int PPN_BITS = 20
) (
  input logic clock,
  input logic reset,
  tlb_entry_cache_if.slave io
);
  localparam int PW = $clog2(ENTRIES);
  logic [VPN_BITS-1:0] tag [ENTRIES];
  tlb_entry_t data [ENTRIES];
  logic [ENTRIES-1:0] valid, lhit, rhit, shit, sel;
  logic [PW-1:0] ptr;
  logic adv, fire;
  tlb_entry_t rd, wr;
  always_comb begin
    lhit = '0;
    rhit = '0;
    shit = '0;
    rd = '0;
    wr.ppn = PPN_W'(io.refill_ppn);
    wr.flags = io.refill_flags;
    for (int i = 0; i < ENTRIES; i++) begin
      lhit[i] = valid[i] && tag[i] == io.req_vpn;
      rhit[i] = valid[i] && tag[i] == io.refill_vpn;
      shit[i] = valid[i] && tag[i] == io.sfence_vpn;
      rd = rd | (lhit[i] ? data[i] : '0);
    end
  end
  assign io.refill_ready = !io.sfence_valid && !reset;
  assign fire = io.refill_valid && io.refill_ready;
  tlb_entry_victim_sel #(.ENTRIES(ENTRIES)) u_victim (
    .valid(valid),
    .hit(rhit),
    .ptr(ptr),
    .sel(sel),
    .adv(adv)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      ptr <= '0;
      io.resp_valid <= 1'b0;
      io.resp_hit <= 1'b0;
      io.resp_ppn <= '0;
      io.resp_flags <= '0;
    end else begin
      io.resp_valid <= io.req_valid;
      io.resp_hit <= io.req_valid && (|lhit);
      io.resp_ppn <= io.req_valid ? PPN_BITS'(rd.ppn) : '0;
      io.resp_flags <= io.req_valid ? rd.flags : '0;
      if (io.sfence_valid)
        valid <= io.sfence_rs1 ? (valid & ~shit) : '0;
      else if (fire) begin
        valid <= valid | sel;
        if (adv) ptr <= ptr + PW'(1);
      end
    end
  end
  // Entry payload needs no reset: valid bits gate every use.
  always_ff @(posedge clock) begin
    for (int i = 0; i < ENTRIES; i++)
      if (fire && sel[i]) begin
        tag[i] <= io.refill_vpn;
        data[i] <= wr;
      end
  end
`ifdef TLB_ENTRY_CACHE_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      io.perf_hits <= '0;
      io.perf_misses <= '0;
    end else begin
      if (io.resp_valid && io.resp_hit && !(&io.perf_hits)) io.perf_hits <= io.perf_hits + 32'd1;
      if (io.resp_valid && !io.resp_hit && !(&io.perf_misses)) io.perf_misses <= io.perf_misses + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_tlb_entry_cache.sv
// tb_tlb_entry_cache: table-driven lookup/refill/sfence vectors plus hand sequences for same-cycle and reset corners.
module tb_tlb_entry_cache;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  typedef enum {LK, RF, SA, SO} op_e;
  typedef struct {
    op_e op;
    logic [26:0] vpn;
    logic [19:0] ppn;
    logic [11:0] flags;
    logic hit;
  } vec_t;
  vec_t q[$];
  localparam logic [26:0] A = 27'h00123;
  localparam logic [26:0] X = 27'h7FFFFFF;
  localparam logic [26:0] Y = 27'h0000ABC;

  tlb_entry_cache_if #(.VPN_BITS(27), .PPN_BITS(20)) io ();
  tlb_entry_cache #(.ENTRIES(8), .VPN_BITS(27), .PPN_BITS(20)) dut (
    .clock(clock),
    .reset(reset),
    .io(io)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [26:0] vv(int i);
    return 27'(32'h100 + i);
  endfunction
  function automatic logic [19:0] pp(int i);
    return 20'(32'h200 + i);
  endfunction
  function automatic logic [11:0] ff(int i);
    return 12'(i * 37);
  endfunction
  function automatic vec_t mk(op_e op, logic [26:0] vpn, logic [19:0] ppn, logic [11:0] fl, logic hit);
    vec_t t;
    t.op = op;
    t.vpn = vpn;
    t.ppn = ppn;
    t.flags = fl;
    t.hit = hit;
    return t;
  endfunction
  function automatic vec_t rf(int i);
    return mk(RF, vv(i), pp(i), ff(i), 1'b0);
  endfunction
  function automatic vec_t lk(int i, logic hit);
    return mk(LK, vv(i), pp(i), ff(i), hit);
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, act, exp);
    end
  endtask

  task automatic idle();
    io.req_valid = 0;
    io.req_vpn = '0;
    io.refill_valid = 0;
    io.refill_vpn = '0;
    io.refill_ppn = '0;
    io.refill_flags = '0;
    io.sfence_valid = 0;
    io.sfence_rs1 = 0;
    io.sfence_vpn = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    idle();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_resp_valid", 32'(io.resp_valid), 0);
    chk("rst_resp_hit", 32'(io.resp_hit), 0);
    chk("rst_resp_ppn", 32'(io.resp_ppn), 0);
    chk("rst_resp_flags", 32'(io.resp_flags), 0);
    chk("rst_ready", 32'(io.refill_ready), 0);
`ifdef TLB_ENTRY_CACHE_PERF_EN
    chk("rst_perf_hits", io.perf_hits, 0);
    chk("rst_perf_misses", io.perf_misses, 0);
`endif
    @(negedge clock);
    reset = 0;
  endtask

  task automatic run_vec(int k, vec_t t);
    @(negedge clock);
    case (t.op)
      LK: begin io.req_valid = 1; io.req_vpn = t.vpn; end
      RF: begin io.refill_valid = 1; io.refill_vpn = t.vpn; io.refill_ppn = t.ppn; io.refill_flags = t.flags; end
      SA: begin io.sfence_valid = 1; io.sfence_rs1 = 0; end
      default: begin io.sfence_valid = 1; io.sfence_rs1 = 1; io.sfence_vpn = t.vpn; end
    endcase
    #1;
    if (t.op == RF) chk($sformatf("v%0d_ready", k), 32'(io.refill_ready), 1);
    @(posedge clock);
    #1;
    idle();
    chk($sformatf("v%0d_resp_valid", k), 32'(io.resp_valid), 32'(t.op == LK));
    if (t.op == LK) begin
      chk($sformatf("v%0d_hit", k), 32'(io.resp_hit), 32'(t.hit));
      chk($sformatf("v%0d_ppn", k), 32'(io.resp_ppn), t.hit ? 32'(t.ppn) : 0);
      chk($sformatf("v%0d_flags", k), 32'(io.resp_flags), t.hit ? 32'(t.flags) : 0);
    end
  endtask

  task automatic run_q(int base);
    foreach (q[k]) run_vec(base + k, q[k]);
    q = {};
  endtask

  initial begin
    idle();
    do_reset();
    q.push_back(mk(LK, A, 20'h0, 12'h0, 0));
    q.push_back(mk(RF, A, 20'hABCDE, 12'hFFF, 0));
    q.push_back(mk(LK, A, 20'hABCDE, 12'hFFF, 1));
    q.push_back(mk(SA, '0, '0, '0, 0));
    q.push_back(mk(LK, A, 20'h0, 12'h0, 0));
    for (int i = 0; i < 8; i++) q.push_back(rf(i));
    q.push_back(lk(0, 1));
    q.push_back(lk(7, 1));
    q.push_back(rf(8));
    q.push_back(lk(0, 0));
    q.push_back(lk(8, 1));
    q.push_back(lk(1, 1));
    q.push_back(rf(9));
    q.push_back(lk(1, 0));
    q.push_back(lk(2, 1));
    q.push_back(mk(RF, vv(2), 20'h11111, ff(2), 0));
    q.push_back(mk(LK, vv(2), 20'h11111, ff(2), 1));
    q.push_back(rf(10));
    q.push_back(lk(2, 0));
    q.push_back(lk(3, 1));
    for (int i = 11; i <= 16; i++) q.push_back(rf(i));
    q.push_back(lk(8, 0));
    q.push_back(lk(9, 1));
    q.push_back(lk(10, 1));
    run_q(0);

    // sfence on v9 collides with a refill and a lookup of v9
    @(negedge clock);
    io.sfence_valid = 1;
    io.sfence_rs1 = 1;
    io.sfence_vpn = vv(9);
    io.refill_valid = 1;
    io.refill_vpn = vv(17);
    io.refill_ppn = pp(17);
    io.refill_flags = ff(17);
    io.req_valid = 1;
    io.req_vpn = vv(9);
    #1;
    chk("sf_ready_low", 32'(io.refill_ready), 0);
    @(posedge clock);
    #1;
    chk("sf_preflush_hit", 32'(io.resp_hit), 1);
    chk("sf_preflush_ppn", 32'(io.resp_ppn), 32'(pp(9)));
    io.sfence_valid = 0;
    #1;
    chk("sf_ready_back", 32'(io.refill_ready), 1);
    @(posedge clock);
    #1;
    chk("sf_v9_gone", 32'(io.resp_hit), 0);
    chk("sf_v9_valid", 32'(io.resp_valid), 1);
    idle();

    q.push_back(lk(17, 1));
    q.push_back(lk(10, 1));
    q.push_back(lk(16, 1));
    q.push_back(rf(18));
    q.push_back(lk(17, 0));
    q.push_back(lk(18, 1));
    q.push_back(lk(10, 1));
    q.push_back(mk(SO, vv(99), '0, '0, 0));
    q.push_back(lk(10, 1));
    q.push_back(mk(SA, '0, '0, '0, 0));
    q.push_back(lk(10, 0));
    q.push_back(lk(18, 0));
    run_q(100);

    // lookup and refill of the same VPN in one cycle
    do_reset();
    @(negedge clock);
    io.req_valid = 1;
    io.req_vpn = X;
    io.refill_valid = 1;
    io.refill_vpn = X;
    io.refill_ppn = 20'h54321;
    io.refill_flags = 12'hA5A;
    @(posedge clock);
    #1;
    idle();
    chk("same_cyc_valid", 32'(io.resp_valid), 1);
    chk("same_cyc_miss", 32'(io.resp_hit), 0);
    @(negedge clock);
    io.req_valid = 1;
    io.req_vpn = X;
    @(posedge clock);
    #1;
    idle();
    chk("same_next_hit", 32'(io.resp_hit), 1);
    chk("same_next_ppn", 32'(io.resp_ppn), 32'h54321);
    chk("same_next_flags", 32'(io.resp_flags), 32'hA5A);
    @(posedge clock);
    #1;
`ifdef TLB_ENTRY_CACHE_PERF_EN
    chk("perf_hits", io.perf_hits, 1);
    chk("perf_misses", io.perf_misses, 1);
`endif
    chk("idle_resp_valid", 32'(io.resp_valid), 0);
    q.push_back(mk(LK, 27'h3FFFFFF, '0, '0, 0));
    q.push_back(mk(LK, 27'h7FFFFFE, '0, '0, 0));
    q.push_back(mk(LK, X, 20'h54321, 12'hA5A, 1));
    run_q(200);

    // reset arrives with a refill pending
    @(negedge clock);
    reset = 1;
    io.refill_valid = 1;
    io.refill_vpn = Y;
    io.refill_ppn = 20'h0F0F0;
    io.refill_flags = 12'h123;
    io.req_valid = 1;
    io.req_vpn = X;
    #1;
    chk("rst_mid_ready", 32'(io.refill_ready), 0);
    @(posedge clock);
    #1;
    chk("rst_mid_resp_valid", 32'(io.resp_valid), 0);
    @(negedge clock);
    reset = 0;
    idle();
    @(posedge clock);
    #1;
    chk("post_rst_resp_valid", 32'(io.resp_valid), 0);
    q.push_back(mk(LK, X, '0, '0, 0));
    q.push_back(mk(LK, Y, '0, '0, 0));
    q.push_back(mk(RF, Y, 20'h0F0F0, 12'h123, 0));
    q.push_back(mk(LK, Y, 20'h0F0F0, 12'h123, 1));
    run_q(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
